// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a valid/ready memory port,
// holds the instruction while it executes and computes the next PC on retire.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] signimm,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic [31:0] retired_q;
    logic [31:0] retired_d;
    logic [31:0] pc_next;

    assign pcplus4     = pc_q + 32'd4;
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign retired     = retired_q;
    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == VALID);

    // Jump beats branch; the branch offset is in words and wraps at 2^32.
    always_comb begin
        pc_next = pcplus4;
        if (jump) begin
            pc_next = {pcplus4[31:28], instr_q[25:0], 2'b00};
        end else if (pcsrc) begin
            pc_next = pcplus4 + (signimm << 2);
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: begin
                if (!halt) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                // halt is only honoured here or in IDLE, never mid-fetch.
                if (instr_ack) begin
                    pc_d      = pc_next;
                    retired_d = retired_q + 32'd1;
                    state_d   = halt ? IDLE : FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model checked every cycle
// plus hand-computed literal expectations for each scenario.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic        pcsrc;
    logic        jump;
    logic [31:0] signimm;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] retired;

    int check_count = 0;
    int pass_count  = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .halt       (halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ack  (instr_ack),
        .pcsrc      (pcsrc),
        .jump       (jump),
        .signimm    (signimm),
        .pc         (pc),
        .pcplus4    (pcplus4),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an instruction is either being requested, being held, or neither.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_retired;
    logic        m_requesting;
    logic        m_holding;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc         = 32'h0000_0000;
            m_instr      = 32'd0;
            m_retired    = 32'd0;
            m_requesting = 1'b0;
            m_holding    = 1'b0;
        end else if (m_holding) begin
            if (instr_ack) begin
                if (jump)
                    m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 32'd4);
                else if (pcsrc)
                    m_pc = m_pc + 32'd4 + signimm * 32'd4;
                else
                    m_pc = m_pc + 32'd4;
                m_retired    = m_retired + 32'd1;
                m_holding    = 1'b0;
                m_requesting = !halt;
            end
        end else if (m_requesting) begin
            if (imem_ready) begin
                m_instr      = imem_rdata;
                m_requesting = 1'b0;
                m_holding    = 1'b1;
            end
        end else if (!halt) begin
            m_requesting = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("model imem_req", {31'd0, imem_req}, {31'd0, m_requesting});
            checkOutput("model instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
            checkOutput("model pc", pc, m_pc);
            checkOutput("model imem_addr", imem_addr, m_pc);
            checkOutput("model pcplus4", pcplus4, m_pc + 32'd4);
            checkOutput("model instr", instr, m_instr);
            checkOutput("model retired", retired, m_retired);
        end
    end

    task automatic applyStimulus(input logic h, input logic rdy, input logic [31:0] rd,
                                 input logic ack, input logic ps, input logic jp,
                                 input logic [31:0] si);
        halt       = h;
        imem_ready = rdy;
        imem_rdata = rd;
        instr_ack  = ack;
        pcsrc      = ps;
        jump       = jp;
        signimm    = si;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        halt = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        instr_ack = 1'b0;
        pcsrc = 1'b0;
        jump = 1'b0;
        signimm = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset pc", pc, 32'h0);
        checkOutput("reset imem_req", {31'd0, imem_req}, 32'd0);
        checkOutput("reset instr_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("reset instr", instr, 32'h0);
        checkOutput("reset retired", retired, 32'h0);
        reset = 1'b1;

        // Zero-wait fetch of the first instruction, retired immediately.
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("c1 imem_req", {31'd0, imem_req}, 32'd1);
        checkOutput("c1 imem_addr", imem_addr, 32'h0);
        applyStimulus(0, 1, 32'h2008_0005, 0, 0, 0, 32'h0);
        checkOutput("c2 instr_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("c2 instr", instr, 32'h2008_0005);
        applyStimulus(0, 0, 32'h0, 1, 0, 0, 32'h0);
        checkOutput("ack pc", pc, 32'h4);
        checkOutput("ack retired", retired, 32'd1);
        checkOutput("ack next req", {31'd0, imem_req}, 32'd1);
        applyStimulus(0, 1, 32'h0000_0020, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 0, 0, 32'h0);

        // Three wait states at pc 8.
        for (int i = 0; i < 3; i++) begin
            checkOutput("wait imem_req", {31'd0, imem_req}, 32'd1);
            checkOutput("wait imem_addr", imem_addr, 32'h8);
            checkOutput("wait instr_valid", {31'd0, instr_valid}, 32'd0);
            applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0);
        end
        checkOutput("wait4 imem_addr", imem_addr, 32'h8);
        applyStimulus(0, 1, 32'h1000_000D, 0, 0, 0, 32'h0);
        checkOutput("wait valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("wait instr", instr, 32'h1000_000D);

        // Branch from 8 to 0x40, then the self-loop and a forward branch.
        applyStimulus(0, 0, 32'h0, 1, 1, 0, 32'd13);
        checkOutput("br to 40", pc, 32'h40);
        applyStimulus(0, 1, 32'h1000_FFFF, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 1, 0, 32'hFFFF_FFFF);
        checkOutput("br self loop", pc, 32'h40);
        applyStimulus(0, 1, 32'h1000_0003, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 1, 0, 32'd3);
        checkOutput("br fwd", pc, 32'h50);

        // Reach 0x1000_0010 by branch, then jump with pcsrc also set.
        applyStimulus(0, 1, 32'h1000_0000, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 1, 0, 32'h03FF_FFEF);
        checkOutput("br far", pc, 32'h1000_0010);
        applyStimulus(0, 1, 32'h0800_0100, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 1, 1, 32'd5);
        checkOutput("jump wins", pc, 32'h1000_0400);
        checkOutput("jump retired", retired, 32'd7);

        // Spurious ack in FETCH and spurious ready in VALID.
        applyStimulus(0, 0, 32'h0, 1, 1, 1, 32'd7);
        checkOutput("stray ack pc", pc, 32'h1000_0400);
        checkOutput("stray ack retired", retired, 32'd7);
        checkOutput("stray ack req", {31'd0, imem_req}, 32'd1);
        applyStimulus(0, 1, 32'hAAAA_5555, 0, 0, 0, 32'h0);
        applyStimulus(0, 1, 32'h1234_5678, 0, 0, 0, 32'h0);
        checkOutput("stray ready instr", instr, 32'hAAAA_5555);
        checkOutput("stray ready pc", pc, 32'h1000_0400);
        applyStimulus(0, 0, 32'h0, 1, 0, 0, 32'h0);
        checkOutput("plain retire", pc, 32'h1000_0404);

        // Wrapping branch to 0x20, then reset during a wait-stated fetch.
        applyStimulus(0, 1, 32'h1000_0001, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 1, 0, 32'h3BFF_FF06);
        checkOutput("wrap to 20", pc, 32'h20);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0);
        reset = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("async rst req", {31'd0, imem_req}, 32'd0);
        checkOutput("async rst pc", pc, 32'h0);
        checkOutput("async rst retired", retired, 32'd0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("rst ready ignored", instr, 32'h0);
        checkOutput("rst held req", {31'd0, imem_req}, 32'd0);
        reset = 1'b1;
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("restart addr", imem_addr, 32'h0);
        checkOutput("restart req", {31'd0, imem_req}, 32'd1);
        applyStimulus(0, 1, 32'h0000_0001, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 0, 0, 32'h0);
        applyStimulus(0, 1, 32'h0000_0002, 0, 0, 0, 32'h0);

        // halt held through the retire parks in IDLE.
        applyStimulus(1, 0, 32'h0, 1, 0, 0, 32'h0);
        checkOutput("halt pc", pc, 32'h8);
        checkOutput("halt req", {31'd0, imem_req}, 32'd0);
        checkOutput("halt valid", {31'd0, instr_valid}, 32'd0);
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("halt parked", {31'd0, imem_req}, 32'd0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("resume req", {31'd0, imem_req}, 32'd1);
        checkOutput("resume addr", imem_addr, 32'h8);

        // halt rising mid-fetch does not abort; then wrap pcplus4.
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0);
        checkOutput("halt in fetch", {31'd0, imem_req}, 32'd1);
        applyStimulus(1, 1, 32'h0000_0003, 0, 0, 0, 32'h0);
        checkOutput("halt fetch done", {31'd0, instr_valid}, 32'd1);
        applyStimulus(0, 0, 32'h0, 1, 1, 0, 32'hFFFF_FFFC);
        checkOutput("top pc", pc, 32'hFFFF_FFFC);
        checkOutput("pcplus4 wrap", pcplus4, 32'h0);
        applyStimulus(0, 1, 32'h0000_0004, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 32'h0, 1, 0, 0, 32'h0);
        checkOutput("pc wrap", pc, 32'h0);
        checkOutput("final retired", retired, 32'd4);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the main decoder/ALU-decoder control path. It owns the program counter, fetches each instruction over a valid/ready instruction-memory port, and holds it stable while the control and datapath execute it. When the datapath retires the instruction, the block computes the next PC from the resolved `pcsrc`/`jump` controls and the sign-extended immediate. This replaces the ideal single-cycle instruction ROM with a memory that may insert wait states.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `halt`  in  1  holds the block in IDLE; no new fetch is issued while it is high.
- `imem_req`  out  1  fetch request; held high until `imem_ready` is sampled.
- `imem_addr`  out  32  fetch address; always equals `pc` while `imem_req` is high.
- `imem_ready`  in  1  memory response valid; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word returned by memory.
- `instr`  out  32  held instruction; `op` = [31:26], `funct` = [5:0] feed the controller.
- `instr_valid`  out  1  `instr` is valid and is being executed.
- `instr_ack`  in  1  datapath retires the current instruction; next-PC inputs are valid.
- `pcsrc`  in  1  branch taken (resolved by the controller); sampled on ack.
- `jump`  in  1  jump instruction; sampled on ack; takes priority over `pcsrc`.
- `signimm`  in  32  sign-extended 16-bit immediate of the current instruction.
- `pc`  out  32  address of the current/pending instruction.
- `pcplus4`  out  32  `pc + 4`, combinational.
- `retired`  out  32  count of acknowledged instructions; wraps modulo 2^32.

## Operation
- States: IDLE, FETCH, VALID.
- IDLE: `imem_req` = 0.
  - If `halt` = 0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: `imem_req` = 1 and `imem_addr` = `pc`.
  - On `imem_ready` = 1, capture `imem_rdata` into `instr` and go to VALID.
  - Otherwise stay in FETCH; address and request remain stable.
- VALID: `instr_valid` = 1 and `instr` is held.
  - On `instr_ack` = 1, load `pc` with the next PC and increment `retired`.
  - Then go to IDLE if `halt` = 1, else go to FETCH.
- Next PC, in priority order:
  - `jump`: {`pcplus4`[31:28], `instr`[25:0], 2'b00}.
  - else `pcsrc`: `pcplus4` + (`signimm` << 2), 32-bit add, carry discarded (wraps).
  - else: `pcplus4`.
- `pc` changes only on an acknowledged retire or on reset.
- `instr_ack` outside VALID is ignored; `pcsrc`, `jump` and `signimm` are then don't-care.
- `imem_ready` outside FETCH is ignored, and `instr` is unchanged.
- `halt` rising during FETCH does not abort the outstanding fetch. It only takes effect in IDLE or at the retire in VALID.
- `pcplus4` wraps from 32'hFFFF_FFFC to 32'h0000_0000.

## Timing
- Reset asserted: all outputs change asynchronously, without waiting for a clock edge.
  - State = IDLE, `pc` = `RESET_PC`, `instr` = 0.
  - `instr_valid` = 0, `imem_req` = 0, `retired` = 0.
- First edge after reset release with `halt` = 0: IDLE→FETCH, so `imem_req` is high in cycle 1.
- Zero-wait memory (`imem_ready` high in the first FETCH cycle): `instr_valid` is high in the following cycle.
- Each wait cycle extends FETCH by one cycle.
- Retire with ack in the first VALID cycle: the next `imem_req` is asserted in the cycle after the ack.
  - Steady-state throughput with zero-wait memory: one instruction every 2 cycles.
- Reset asserted mid-FETCH or mid-VALID: the transaction is abandoned immediately, with no ack, counter increment or PC update. A late `imem_ready` after reset is ignored.
- Outputs are registered, except `pcplus4`, `imem_addr` (= `pc`) and `instr_valid`/`imem_req`, which are decoded from state.

## Test plan
- Reset with `RESET_PC` = 0, zero-wait memory returning 32'h2008_0005, ack in the first VALID cycle.
  - Required: `imem_addr` = 0 in cycle 1, `instr` = 32'h2008_0005 valid in cycle 2.
  - Required: after the ack, `pc` = 4 and `retired` = 1.
- Memory with 3 wait states at pc = 8.
  - Required: `imem_req` and `imem_addr` = 8 stable for 4 cycles.
  - Required: `instr_valid` rises exactly one cycle after `imem_ready`.
- Branch at pc = 32'h40 with `pcsrc` = 1 and `signimm` = 32'hFFFF_FFFF.
  - Required: next `pc` = 32'h40, a self-loop.
  - Repeat with `signimm` = 3: next `pc` = 32'h50.
- Jump at pc = 32'h1000_0010 with `instr`[25:0] = 26'h000_0100 and `pcsrc` = 1 also asserted.
  - Required: next `pc` = 32'h1000_0400, because jump wins over the branch.
- `instr_ack` pulsed during FETCH, and a spurious `imem_ready` during VALID.
  - Required: no change to `pc`, `instr` or `retired`.
- Reset asserted during a wait-stated FETCH at pc = 32'h20.
  - Required: `imem_req` drops immediately and `pc` = `RESET_PC`.
  - Required: `imem_ready` arriving during reset is ignored, and fetch restarts from `RESET_PC`.
- `halt` held high through a retire.
  - Required: state parks in IDLE with the updated `pc` and `imem_req` = 0.
  - Required: fetch resumes one cycle after `halt` falls.
